// File: rtl/print_mech_pkg.sv
// Shared definitions for the print-line serialiser: packet framing byte,
// serialiser state encoding and a saturating counter helper.
package print_mech_pkg;

  localparam logic [7:0] PKT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } serialiser_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous line FIFO. A push while full is only taken when a pop frees
// the head slot in the same cycle; otherwise it is ignored.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("line_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/print_line_serialiser.sv
// Captures completed print lines into a line FIFO and streams each one as a
// framed packet (A5 | seq | data bytes | checksum) on a valid/ready byte port.
module print_line_serialiser
  import print_mech_pkg::*;
#(
  parameter int HEAD_WIDTH = 384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_valid,
  input  logic [HEAD_WIDTH-1:0]         line_data,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   dropped_count
);

  localparam int NBYTES  = HEAD_WIDTH / 8;
  localparam int CNT_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int ENTRY_W = HEAD_WIDTH + 8;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  if ((HEAD_WIDTH % 8) != 0) begin : g_bad_width
    $error("print_line_serialiser: HEAD_WIDTH must be a multiple of 8");
  end

  serialiser_state_e       r_state;
  logic [7:0]              r_seq;
  logic [15:0]             r_dropped;
  logic [HEAD_WIDTH-1:0]   r_shift;
  logic [7:0]              r_csum;
  logic [CNT_W-1:0]        r_byte_cnt;
  logic [7:0]              r_out_data;
  logic                    r_out_valid;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_drop;
  logic [ENTRY_W-1:0]      w_head;

  assign w_pop  = (r_state == IDLE) & ~w_empty;
  assign w_drop = line_valid & w_full & ~w_pop;

  line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (line_valid),
    .i_pop   (w_pop),
    .i_wdata ({r_seq, line_data}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Sequence numbers advance on every line, so a drop shows up as a gap at the host
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq     <= 8'h00;
      r_dropped <= 16'h0000;
    end else begin
      if (line_valid) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_drop) begin
        r_dropped <= sat_inc16(r_dropped);
      end
    end
  end

  // Packet FSM; r_csum is seeded with the line's seq so it doubles as the SEQ byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_csum      <= 8'h00;
      r_byte_cnt  <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift     <= w_head[HEAD_WIDTH-1:0];
            r_csum      <= w_head[ENTRY_W-1:HEAD_WIDTH];
            r_out_data  <= PKT_SYNC_BYTE;
            r_out_valid <= 1'b1;
            r_state     <= SYNC;
          end
        end
        SYNC: begin
          if (out_ready) begin
            r_out_data <= r_csum;
            r_state    <= SEQ;
          end
        end
        SEQ: begin
          if (out_ready) begin
            r_out_data <= r_shift[7:0];
            r_shift    <= r_shift >> 4'd8;
            r_byte_cnt <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (out_ready) begin
            r_csum <= r_csum + r_out_data;
            if (r_byte_cnt == LAST_BYTE) begin
              r_out_data <= r_csum + r_out_data;
              r_state    <= CSUM;
            end else begin
              r_out_data <= r_shift[7:0];
              r_shift    <= r_shift >> 4'd8;
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        CSUM: begin
          if (out_ready) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign dropped_count = r_dropped;
  assign busy          = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_print_line_serialiser.sv
// Directed bench for print_line_serialiser with HEAD_WIDTH=16, FIFO_DEPTH=4.
module tb_print_line_serialiser;

  logic        clk;
  logic        reset;
  logic        line_valid;
  logic [15:0] line_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] dropped_count;

  int n_checks;
  int n_errors;
  logic [7:0] pkt [5];

  print_line_serialiser #(
    .HEAD_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_valid    (line_valid),
    .line_data     (line_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    line_valid = 1'b0;
    line_data  = 16'h0000;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] d);
    line_valid = 1'b1;
    line_data  = d;
    @(negedge clk);
    line_valid = 1'b0;
  endtask

  // Gathers one 5-byte packet; checks output stability whenever the sink stalls
  task automatic collect(input bit rnd);
    int got;
    int cyc;
    bit stalled;
    logic [7:0] held;
    got = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while (got < 5 && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        pkt[got] = out_data;
        got++;
        stalled = 1'b0;
      end else if (out_valid) begin
        held    = out_data;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("collect_timeout", 32'(got), 32'd5);
  endtask

  task automatic chk_pkt(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    chk({tag, "_sync"}, 32'(pkt[0]), 32'h0000_00A5);
    chk({tag, "_seq"},  32'(pkt[1]), 32'(b1));
    chk({tag, "_d0"},   32'(pkt[2]), 32'(b2));
    chk({tag, "_d1"},   32'(pkt[3]), 32'(b3));
    chk({tag, "_csum"}, 32'(pkt[4]), 32'(b4));
  endtask

  initial begin
    int k;
    bit seen_idle;
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(dropped_count), 32'd0);

    // 1: single line, latency and checksum (EF+BE = 1AD -> AD)
    pulse(16'hBEEF);
    chk("t1_lat_n1", 32'(out_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_lat_n2_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_n2_data", 32'(out_data), 32'h0000_00A5);
    collect(1'b0);
    chk_pkt("t1", 8'h00, 8'hEF, 8'hBE, 8'hAD);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(out_valid), 32'd0);

    // 2: random backpressure
    do_reset();
    pulse(16'h0102);
    collect(1'b1);
    chk_pkt("t2", 8'h00, 8'h02, 8'h01, 8'h03);

    // 3: overflow with sink stalled; line 0 is popped into the FSM before line 5 arrives
    do_reset();
    for (int i = 0; i < 6; i++) begin
      line_valid = 1'b1;
      line_data  = 16'h3000 | 16'(i);
      @(negedge clk);
    end
    line_valid = 1'b0;
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_drop", 32'(dropped_count), 32'd1);
    chk("t3_stall_valid", 32'(out_valid), 32'd1);
    chk("t3_stall_data", 32'(out_data), 32'h0000_00A5);
    for (int p = 0; p < 5; p++) begin
      collect(1'b0);
      chk_pkt("t3", 8'(p), 8'(p), 8'h30, 8'(8'h30 + 8'(2 * p)));
    end
    chk("t3_drop_end", 32'(dropped_count), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4: sequence wrap over 257 lines
    do_reset();
    for (int i = 0; i < 257; i++) begin
      pulse(16'(i));
      collect(1'b0);
      chk("t4_seq", 32'(pkt[1]), 32'(i & 8'hFF));
    end
    chk("t4_drop", 32'(dropped_count), 32'd0);

    // 5: FIFO full while the FSM pops in IDLE: coincident push is accepted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      line_valid = 1'b1;
      line_data  = 16'h5000 | 16'(i);
      @(negedge clk);
    end
    line_valid = 1'b0;
    chk("t5_full_level", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    seen_idle = 1'b0;
    k = 0;
    while (!seen_idle && k < 20) begin
      @(negedge clk);
      k++;
      if (!out_valid) seen_idle = 1'b1;
    end
    out_ready = 1'b0;
    chk("t5_idle_reached", 32'(seen_idle), 32'd1);
    chk("t5_idle_level", 32'(fifo_level), 32'd4);
    pulse(16'h5005);
    chk("t5_drop", 32'(dropped_count), 32'd0);
    chk("t5_level_after", 32'(fifo_level), 32'd4);
    for (int p = 1; p < 6; p++) begin
      collect(1'b0);
      chk_pkt("t5", 8'(p), 8'(p), 8'h50, 8'(8'h50 + 8'(2 * p)));
    end

    // 6: reset in the middle of the second data byte
    do_reset();
    out_ready  = 1'b1;
    line_valid = 1'b1;
    line_data  = 16'hCAFE;
    @(negedge clk);
    line_data  = 16'h1111;
    @(negedge clk);
    line_valid = 1'b0;
    chk("t6_sync", 32'(out_data), 32'h0000_00A5);
    @(negedge clk);
    chk("t6_seq", 32'(out_data), 32'h0000_0000);
    @(negedge clk);
    chk("t6_d0", 32'(out_data), 32'h0000_00FE);
    @(negedge clk);
    chk("t6_d1", 32'(out_data), 32'h0000_00CA);
    chk("t6_level_pre", 32'(fifo_level), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_partial", 32'(out_valid), 32'd0);
    end
    pulse(16'h0405);
    collect(1'b0);
    chk_pkt("t6", 8'h00, 8'h05, 8'h04, 8'h09);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
